// File: rtl/final_soc_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : final_soc_led_pkg
//  Purpose : Shared constants for the LED output peripheral. It holds the
//            Avalon-MM word offsets of the four registers and the default
//            widths of the output port and of the pulse-length counter.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package final_soc_led_pkg;

   // Register word offsets on the Avalon-MM slave
   localparam logic [1:0] ADDR_DATA      = 2'd0;
   localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
   localparam logic [1:0] ADDR_PULSE_SET = 2'd2;
   localparam logic [1:0] ADDR_OUTCLEAR  = 2'd3;

   // Default geometry
   localparam int DEFAULT_WIDTH = 10;
   localparam int DEFAULT_CNT_W = 24;

endpackage : final_soc_led_pkg
`default_nettype wire

// File: rtl/final_soc_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module  : final_soc_pulse_timer
//  Purpose : Down-counter that times auto-clearing LED pulses. A load
//            restarts the count, a clear cancels it, and the counter
//            otherwise decrements toward zero and holds there.
//  Ports   : clk, reset_n     - clock, asynchronous active-low reset
//            load, load_value - restart the count with load_value
//            clear            - force the count to zero (highest priority)
//            cnt              - current count
//            expire           - high for the one cycle whose rising edge
//                               takes cnt from 1 to 0
//  Rev     : 1.0  initial release
// ============================================================================
module final_soc_pulse_timer
   import final_soc_led_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt,
   output logic             expire
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   // A load or clear in the final cycle pre-empts the expiry, so the pulse
   // is either restarted or cancelled instead of clearing its bits.
   assign expire = (cnt == CNT_ONE) && !load && !clear;

endmodule : final_soc_pulse_timer
`default_nettype wire

// File: rtl/final_soc_led_out.sv
`default_nettype none
// ============================================================================
//  Module  : final_soc_led_out
//  Purpose : Avalon-MM LED output port with timed pulses. DATA sets the
//            outputs directly; PULSE_SET raises bits that drop again after
//            PULSE_LEN cycles; OUTCLEAR drops bits immediately.
//  Ports   : clk, reset_n   - clock, asynchronous active-low reset
//            address        - word offset (DATA/PULSE_LEN/PULSE_SET/OUTCLEAR)
//            chipselect     - slave select
//            write_n        - active-low write strobe
//            writedata      - 32-bit write data
//            readdata       - registered read data, zero-extended
//            out_port       - LED outputs, straight from the data register
//  Rev     : 1.0  initial release
// ============================================================================
module final_soc_led_out
   import final_soc_led_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter int               CNT_W       = DEFAULT_CNT_W,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] pulse_mask;
   logic [CNT_W-1:0] pulse_len;
   logic [CNT_W-1:0] cnt;
   logic             expire;

   logic [WIDTH-1:0] data_next;
   logic [WIDTH-1:0] mask_next;
   logic [31:0]      rd_next;

   logic [WIDTH-1:0] wd;
   logic             wr;
   logic             wr_data;
   logic             wr_len;
   logic             wr_set;
   logic             wr_clr;
   logic             timer_load;
   logic             unused_wd_bits;

   assign wd      = writedata[WIDTH-1:0];
   assign wr      = chipselect && !write_n;
   assign wr_data = wr && (address == ADDR_DATA);
   assign wr_len  = wr && (address == ADDR_PULSE_LEN);
   assign wr_set  = wr && (address == ADDR_PULSE_SET);
   assign wr_clr  = wr && (address == ADDR_OUTCLEAR);

   // Only a PULSE_SET with a non-zero length arms the timer; a zero
   // length makes PULSE_SET a plain sticky set.
   assign timer_load = wr_set && (pulse_len != '0);

   // Upper write-data bits beyond the register widths are ignored.
   assign unused_wd_bits = ^writedata;

   final_soc_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (pulse_len),
      .clear      (wr_data),
      .cnt        (cnt),
      .expire     (expire)
   );

   // Expiry is applied first and the write is layered on top of it, so an
   // OUTCLEAR in the expiry cycle removes both its own bits and the pulsed
   // bits. DATA writes and arming PULSE_SETs suppress expire in the timer.
   always_comb begin
      data_next = data;
      mask_next = pulse_mask;
      if (expire) begin
         data_next = data & ~pulse_mask;
         mask_next = '0;
      end
      if (wr_data) begin
         data_next = wd;
         mask_next = '0;
      end else if (timer_load) begin
         data_next = data | wd;
         mask_next = pulse_mask | wd;
      end else if (wr_set) begin
         data_next = data_next | wd;
      end else if (wr_clr) begin
         data_next = data_next & ~wd;
         mask_next = mask_next & ~wd;
      end
   end

   // Read mux, registered every cycle from the current address.
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:      rd_next[WIDTH-1:0] = data;
         ADDR_PULSE_LEN: rd_next[CNT_W-1:0] = pulse_len;
         ADDR_PULSE_SET: rd_next[WIDTH-1:0] = pulse_mask;
         default:        rd_next[CNT_W-1:0] = cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data       <= RESET_VALUE;
         pulse_mask <= '0;
         pulse_len  <= '0;
         readdata   <= '0;
      end else begin
         data       <= data_next;
         pulse_mask <= mask_next;
         if (wr_len) begin
            pulse_len <= writedata[CNT_W-1:0];
         end
         readdata   <= rd_next;
      end
   end

   assign out_port = data;

endmodule : final_soc_led_out
`default_nettype wire

// File: tb/tb_final_soc_led_out.sv
`default_nettype none
// ============================================================================
//  Module  : tb_final_soc_led_out
//  Purpose : Self-checking bench for final_soc_led_out. A reference model
//            tracks each pending pulse by its absolute expiry cycle rather
//            than by a countdown register.
//  Ports   : (testbench, none)
//  Rev     : 1.0  initial release
// ============================================================================
module tb_final_soc_led_out;

   localparam int               WIDTH = 10;
   localparam int               CNT_W = 24;
   localparam logic [WIDTH-1:0] RV    = 10'h155;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       address = 2'd0;
   logic             chipselect = 1'b0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = 32'd0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   always #5 clk = ~clk;

   final_soc_led_out #(
      .WIDTH       (WIDTH),
      .CNT_W       (CNT_W),
      .RESET_VALUE (RV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: m_exp is the absolute cycle number of the edge on
   // which pulsed bits drop, or -1 when nothing is pending.
   logic [WIDTH-1:0] m_data;
   logic [WIDTH-1:0] m_mask;
   longint           m_len;
   longint           m_exp;
   longint           now;
   logic [31:0]      m_rd;

   function automatic longint remaining(input longint t);
      return (m_exp > t) ? (m_exp - t) : 64'sd0;
   endfunction

   task automatic model_reset();
      m_data = RV;
      m_mask = '0;
      m_len  = 0;
      m_exp  = -1;
      m_rd   = 32'd0;
   endtask

   task automatic model_edge();
      logic [WIDTH-1:0] wd;
      logic             wr;
      logic             expiring;
      case (address)
         2'd0:    m_rd = 32'(m_data);
         2'd1:    m_rd = 32'(m_len);
         2'd2:    m_rd = 32'(m_mask);
         default: m_rd = 32'(remaining(now));
      endcase
      now++;
      wd       = writedata[WIDTH-1:0];
      wr       = chipselect && !write_n;
      expiring = (m_exp == now);
      if (wr && address == 2'd2 && m_len != 0) begin
         m_data = m_data | wd;
         m_mask = m_mask | wd;
         m_exp  = now + m_len;
      end else begin
         if (expiring) begin
            m_data = m_data & ~m_mask;
            m_mask = '0;
            m_exp  = -1;
         end
         if (wr) begin
            case (address)
               2'd0: begin
                  m_data = wd;
                  m_mask = '0;
                  m_exp  = -1;
               end
               2'd1:    m_len  = longint'(writedata[CNT_W-1:0]);
               2'd2:    m_data = m_data | wd;
               default: begin
                  m_data = m_data & ~wd;
                  m_mask = m_mask & ~wd;
               end
            endcase
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = d;
      @(posedge clk);
      model_edge();
      #1;
      check("out_port", 32'(out_port), 32'(m_data));
      check("readdata", readdata, m_rd);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      step(1'b1, 1'b0, a, d);
   endtask

   task automatic idle(input logic [1:0] a);
      step(1'b0, 1'b1, a, $urandom);
   endtask

   initial begin
      model_reset();
      now = 0;

      // Reset state, sampled while reset is held
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 32'(out_port), 32'(RV));
      check("reset_rd", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // DATA write and read-back
      wr(2'd0, 32'hFFFF_F2A5);
      check("data_out", 32'(out_port), 32'h2A5);
      idle(2'd0);
      check("data_rd", readdata, 32'h0000_02A5);

      // Pulse of 5 cycles on bits [1:0]
      wr(2'd1, 32'hAB00_0005);
      wr(2'd2, 32'h0000_0003);
      repeat (4) idle(2'd3);
      check("pulse5_high", 32'(out_port[1:0]), 32'd3);
      idle(2'd0);
      check("pulse5_clear", 32'(out_port), 32'h2A4);

      // Second PULSE_SET extends the first
      wr(2'd1, 32'd4);
      wr(2'd2, 32'h001);
      idle(2'd2);
      wr(2'd2, 32'h002);
      repeat (3) idle(2'd3);
      check("extend_high", 32'(out_port), 32'h2A7);
      idle(2'd2);
      check("extend_clear", 32'(out_port), 32'h2A4);

      // OUTCLEAR on the expiry cycle
      wr(2'd1, 32'd3);
      wr(2'd2, 32'h00F);
      idle(2'd2);
      idle(2'd2);
      wr(2'd3, 32'h00F);
      check("clr_exp_out", 32'(out_port), 32'h2A0);
      idle(2'd2);
      check("clr_exp_mask", readdata, 32'd0);
      idle(2'd3);
      check("clr_exp_cnt", readdata, 32'd0);

      // DATA write on the expiry cycle wins
      wr(2'd2, 32'h00F);
      idle(2'd0);
      idle(2'd0);
      wr(2'd0, 32'h0C3);
      check("data_exp_out", 32'(out_port), 32'h0C3);
      repeat (3) idle(2'd3);
      check("data_exp_hold", 32'(out_port), 32'h0C3);

      // Zero length: sticky set
      wr(2'd1, 32'd0);
      wr(2'd2, 32'h200);
      repeat (20) idle(2'd3);
      check("sticky_bit9", 32'(out_port), 32'h2C3);

      // Reset in the middle of a long pulse
      wr(2'd1, 32'd100);
      wr(2'd2, 32'h001);
      repeat (10) idle(2'd3);
      @(negedge clk);
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      #1;
      check("midreset_out", 32'(out_port), 32'(RV));
      check("midreset_rd", readdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (110) idle(2'd3);
      check("post_reset_out", 32'(out_port), 32'(RV));
      check("post_reset_cnt", readdata, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [1:0]  a;
         logic [31:0] d;
         int unsigned r;
         a = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         if (a == 2'd1) begin
            d = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 8));
         end else begin
            d = $urandom;
         end
         if (r < 30) begin
            step(1'b1, 1'b0, a, d);
         end else if (r < 40) begin
            step(1'b0, 1'b0, a, d);
         end else if (r < 50) begin
            step(1'b1, 1'b1, a, d);
         end else begin
            idle(a);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_final_soc_led_out
`default_nettype wire
